// File: rtl/pfe_sched_pkg.sv
// Shared types for the partial-fraction coefficient scheduler.
// Complex values are signed Q32.32 fixed point.
package pfe_sched_pkg;

  localparam int FRAC = 32;

  typedef struct packed {
    logic signed [63:0] r;
    logic signed [63:0] i;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    SETTLE
  } state_t;

  localparam cplx_t A_RST = '{r: 64'sd0, i: 64'sd0};
  localparam cplx_t B_RST = '{r: 64'sh1_0000_0000, i: 64'sd0};

  // A pole is usable only strictly in the left half plane.
  function automatic logic cplx_stable(cplx_t b);
    return b.r > 64'sd0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Priority starts at the requester after the last grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]                    req,
  input  logic [(N>1?$clog2(N):1)-1:0]    last,
  input  logic                            enable,
  output logic [N-1:0]                    gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pfe_cplx_coef_sched.sv
// Coefficient scheduler: arbitrated shadow writes, atomic
// bank commit, then a settle hold-off for the PWL filters.
module pfe_cplx_coef_sched
  import pfe_sched_pkg::*;
#(
  parameter int NSEC       = 4,
  parameter int NREQ       = 2,
  parameter int SETTLE_CYC = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NREQ-1:0]                              req_valid,
  output logic [NREQ-1:0]                              req_ready,
  input  logic [NREQ-1:0][(NSEC>1?$clog2(NSEC):1)-1:0] req_sec,
  input  cplx_t [NREQ-1:0]                             req_A,
  input  cplx_t [NREQ-1:0]                             req_B,
  input  logic [NREQ-1:0]                              req_commit,
  output cplx_t [NSEC-1:0]                             A_out,
  output cplx_t [NSEC-1:0]                             B_out,
  output logic                                         busy,
  output logic                                         err_pulse,
  output logic [(NSEC>1?$clog2(NSEC):1)-1:0]           err_sec,
  output logic [15:0]                                  commit_cnt
);

  localparam int SW   = NSEC > 1 ? $clog2(NSEC) : 1;
  localparam int LW   = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(SETTLE_CYC + 2);

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [LW-1:0]     last_grant;
  cplx_t [NSEC-1:0]  sh_a;
  cplx_t [NSEC-1:0]  sh_b;

  logic [NREQ-1:0]   gnt;
  logic [LW-1:0]     sel;
  logic [SW-1:0]     sel_sec;
  cplx_t             sel_a;
  cplx_t             sel_b;
  logic              sel_commit;
  logic [2**SW-1:0]  sec_map;
  logic              xfer;
  logic              reject;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req    (req_valid),
    .last   (last_grant),
    .enable (state == IDLE),
    .gnt    (gnt)
  );

  assign req_ready = gnt;
  assign busy      = (state != IDLE);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) sel = LW'(i);
  end

  // Index values that fit the port but exceed the bank.
  always_comb begin
    sec_map = '0;
    for (int j = 0; j < 2**SW; j++)
      sec_map[j] = (j < NSEC);
  end

  assign sel_sec    = req_sec[sel];
  assign sel_a      = req_A[sel];
  assign sel_b      = req_B[sel];
  assign sel_commit = req_commit[sel];
  assign xfer       = |gnt;
  assign reject     = !sec_map[sel_sec] || !cplx_stable(sel_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= LW'(NREQ - 1);
      sh_a       <= {NSEC{A_RST}};
      sh_b       <= {NSEC{B_RST}};
      A_out      <= {NSEC{A_RST}};
      B_out      <= {NSEC{B_RST}};
      err_pulse  <= 1'b0;
      err_sec    <= '0;
      commit_cnt <= '0;
    end else begin
      err_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            last_grant <= sel;
            if (reject) begin
              err_pulse <= 1'b1;
              err_sec   <= sel_sec;
            end else begin
              for (int j = 0; j < NSEC; j++) begin
                if (SW'(j) == sel_sec) begin
                  sh_a[j] <= sel_a;
                  sh_b[j] <= sel_b;
                end
              end
              if (sel_commit) state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          A_out      <= sh_a;
          B_out      <= sh_b;
          commit_cnt <= commit_cnt + 16'd1;
          if (SETTLE_CYC == 0) begin
            state <= IDLE;
          end else begin
            state <= SETTLE;
            cnt   <= CNTW'(SETTLE_CYC);
          end
        end
        SETTLE: begin
          if (cnt == CNTW'(1)) state <= IDLE;
          else cnt <= cnt - CNTW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pfe_cplx_coef_sched.sv
// Directed bench for pfe_cplx_coef_sched: a default build
// and an NSEC=6, SETTLE_CYC=0 build.
module tb_pfe_cplx_coef_sched;
  import pfe_sched_pkg::*;

  localparam logic signed [63:0] ONE  = 64'sh1_0000_0000;
  localparam logic signed [63:0] HALF = 64'sh8000_0000;
  localparam logic signed [63:0] P2   = 64'sd858993459;
  localparam logic signed [63:0] E9   = 64'sd4294967296000000000;
  localparam logic signed [63:0] E9X2 = 64'sd8589934592000000000;

  localparam cplx_t A_W2 = '{r: HALF, i: P2};
  localparam cplx_t B_W2 = '{r: E9, i: E9X2};
  localparam cplx_t A_W1 = '{r: 64'sh4000_0000, i: 64'sd0};
  localparam cplx_t B_W1 = '{r: 3 * ONE, i: ONE};
  localparam cplx_t A_R0 = '{r: ONE, i: 64'sd0};
  localparam cplx_t B_R0 = '{r: 2 * ONE, i: 64'sd0};
  localparam cplx_t A_R1 = '{r: 64'sd0, i: ONE};
  localparam cplx_t B_R1 = '{r: 5 * ONE, i: 64'sd0};
  localparam cplx_t B_BAD = '{r: -E9, i: 64'sd0};
  localparam cplx_t B_ZR  = '{r: 64'sd0, i: ONE};
  localparam cplx_t A_C = '{r: 7 * ONE, i: -ONE};
  localparam cplx_t B_C = '{r: 4 * ONE, i: 2 * ONE};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       req_valid, req_ready, req_commit;
  logic [1:0][1:0]  req_sec;
  cplx_t [1:0]      req_A, req_B;
  cplx_t [3:0]      A_out, B_out;
  logic             busy, err_pulse;
  logic [1:0]       err_sec;
  logic [15:0]      commit_cnt;

  logic             b_rst;
  logic [1:0]       b_valid, b_ready, b_commit;
  logic [1:0][2:0]  b_sec;
  cplx_t [1:0]      b_A, b_B;
  cplx_t [5:0]      b_A_out, b_B_out;
  logic             b_busy, b_err_pulse;
  logic [2:0]       b_err_sec;
  logic [15:0]      b_commit_cnt;

  int vec = 0;
  int miss = 0;

  pfe_cplx_coef_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sec(req_sec), .req_A(req_A), .req_B(req_B),
    .req_commit(req_commit),
    .A_out(A_out), .B_out(B_out), .busy(busy),
    .err_pulse(err_pulse), .err_sec(err_sec),
    .commit_cnt(commit_cnt)
  );

  pfe_cplx_coef_sched #(.NSEC(6), .NREQ(2), .SETTLE_CYC(0)) dut_z (
    .clk(clk), .rst(b_rst),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_sec(b_sec), .req_A(b_A), .req_B(b_B),
    .req_commit(b_commit),
    .A_out(b_A_out), .B_out(b_B_out), .busy(b_busy),
    .err_pulse(b_err_pulse), .err_sec(b_err_sec),
    .commit_cnt(b_commit_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; b_rst = 1'b1;
    req_valid = '0; req_commit = '0; req_sec = '0;
    req_A = '0; req_B = '0;
    b_valid = '0; b_commit = '0; b_sec = '0;
    b_A = '0; b_B = '0;
    repeat (3) tick();
    rst = 1'b0; b_rst = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      vec++;
      if (A_out[j] !== A_RST || B_out[j] !== B_RST) begin
        miss++;
        $display("FAIL reset_bank[%0d]: A=%h B=%h want A=%h B=%h",
                 j, A_out[j], B_out[j], A_RST, B_RST);
      end
    end
    vec++;
    if ({busy, err_pulse, commit_cnt, req_ready} !== 20'h0) begin
      miss++;
      $display("FAIL reset_ctl: busy=%b err=%b cnt=%h rdy=%b want 0",
               busy, err_pulse, commit_cnt, req_ready);
    end
  endtask

  task automatic test_staged_commit();
    int n;
    req_valid = 2'b01; req_commit = 2'b00;
    req_sec[0] = 2'd2; req_A[0] = A_W2; req_B[0] = B_W2;
    #1;
    vec++;
    if (req_ready !== 2'b01) begin
      miss++;
      $display("FAIL first_grant: got %b want 01", req_ready);
    end
    tick();
    vec++;
    if (A_out[2] !== A_RST || commit_cnt !== 16'd0) begin
      miss++;
      $display("FAIL staged_invisible: A2=%h cnt=%0d want %h 0",
               A_out[2], commit_cnt, A_RST);
    end
    req_sec[0] = 2'd1; req_A[0] = A_W1; req_B[0] = B_W1;
    req_commit = 2'b01;
    tick();
    req_valid = 2'b00; req_commit = 2'b00;
    vec++;
    if (busy !== 1'b1 || A_out[1] !== A_RST) begin
      miss++;
      $display("FAIL commit_pending: busy=%b A1=%h want 1 %h",
               busy, A_out[1], A_RST);
    end
    tick();
    vec++;
    if (A_out[1] !== A_W1 || B_out[1] !== B_W1 ||
        A_out[2] !== A_W2 || B_out[2] !== B_W2 ||
        commit_cnt !== 16'd1) begin
      miss++;
      $display("FAIL commit_atomic: A1=%h A2=%h B2=%h cnt=%0d want %h %h %h 1",
               A_out[1], A_out[2], B_out[2], commit_cnt, A_W1, A_W2, B_W2);
    end
    req_valid = 2'b11;
    #1;
    vec++;
    if (req_ready !== 2'b00) begin
      miss++;
      $display("FAIL settle_ready: got %b want 00", req_ready);
    end
    req_valid = 2'b00;
    n = 2;
    while (busy && n < 40) begin
      tick();
      if (busy) n++;
    end
    vec++;
    if (n !== 9) begin
      miss++;
      $display("FAIL busy_len: got %0d want 9", n);
    end
    req_valid = 2'b01; req_sec[0] = 2'd2;
    req_A[0] = A_W2; req_B[0] = B_W2;
    #1;
    vec++;
    if (req_ready !== 2'b01) begin
      miss++;
      $display("FAIL ready_after_settle: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    req_sec[0] = 2'd0; req_A[0] = A_R0; req_B[0] = B_R0;
    req_sec[1] = 2'd3; req_A[1] = A_R1; req_B[1] = B_R1;
    req_commit = 2'b00;
    req_valid = 2'b11;
    exp_g = 2'b10;
    for (int c = 0; c < 4; c++) begin
      #1;
      vec++;
      if (req_ready !== exp_g) begin
        miss++;
        $display("FAIL rr_cycle%0d: got %b want %b", c, req_ready, exp_g);
      end
      tick();
      exp_g = ~exp_g;
    end
    req_valid = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      vec++;
      if (req_ready !== 2'b10) begin
        miss++;
        $display("FAIL single_req%0d: got %b want 10", c, req_ready);
      end
      tick();
    end
    req_valid = 2'b00;
    vec++;
    if (A_out[0] !== A_RST || commit_cnt !== 16'd1) begin
      miss++;
      $display("FAIL rr_no_commit: A0=%h cnt=%0d want %h 1",
               A_out[0], commit_cnt, A_RST);
    end
  endtask

  task automatic test_reject();
    req_valid = 2'b10; req_commit = 2'b10;
    req_sec[1] = 2'd3; req_B[1] = B_BAD;
    tick();
    vec++;
    if (err_pulse !== 1'b1 || err_sec !== 2'd3 || busy !== 1'b0) begin
      miss++;
      $display("FAIL reject_neg: err=%b sec=%0d busy=%b want 1 3 0",
               err_pulse, err_sec, busy);
    end
    req_sec[1] = 2'd1; req_B[1] = B_ZR;
    tick();
    req_valid = 2'b00; req_commit = 2'b00;
    vec++;
    if (err_pulse !== 1'b1 || err_sec !== 2'd1 || busy !== 1'b0) begin
      miss++;
      $display("FAIL reject_zero: err=%b sec=%0d busy=%b want 1 1 0",
               err_pulse, err_sec, busy);
    end
    tick();
    vec++;
    if (err_pulse !== 1'b0 || commit_cnt !== 16'd1 || busy !== 1'b0) begin
      miss++;
      $display("FAIL reject_after: err=%b cnt=%0d busy=%b want 0 1 0",
               err_pulse, commit_cnt, busy);
    end
  endtask

  task automatic test_reset_in_settle();
    req_valid = 2'b01; req_commit = 2'b01;
    req_sec[0] = 2'd0; req_A[0] = A_C; req_B[0] = B_C;
    tick();
    req_valid = 2'b00; req_commit = 2'b00;
    tick();
    vec++;
    if (A_out[0] !== A_C || B_out[3] !== B_R1 || B_out[1] !== B_W1 ||
        A_out[2] !== A_W2 || commit_cnt !== 16'd2) begin
      miss++;
      $display("FAIL commit2: A0=%h B3=%h B1=%h cnt=%0d want %h %h %h 2",
               A_out[0], B_out[3], B_out[1], commit_cnt, A_C, B_R1, B_W1);
    end
    repeat (3) tick();
    rst = 1'b1;
    #1;
    vec++;
    if (A_out !== {4{A_RST}} || B_out !== {4{B_RST}} ||
        busy !== 1'b0 || commit_cnt !== 16'd0) begin
      miss++;
      $display("FAIL async_reset: A0=%h B0=%h busy=%b cnt=%0d want reset",
               A_out[0], B_out[0], busy, commit_cnt);
    end
    tick();
    rst = 1'b0;
    req_valid = 2'b01;
    #1;
    vec++;
    if (req_ready !== 2'b01) begin
      miss++;
      $display("FAIL ready_post_reset: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_zero_settle();
    b_valid = 2'b01; b_commit = 2'b01;
    b_sec[0] = 3'd6; b_A[0] = A_W1; b_B[0] = B_W1;
    tick();
    vec++;
    if (b_err_pulse !== 1'b1 || b_err_sec !== 3'd6 || b_busy !== 1'b0) begin
      miss++;
      $display("FAIL sec_range: err=%b sec=%0d busy=%b want 1 6 0",
               b_err_pulse, b_err_sec, b_busy);
    end
    b_sec[0] = 3'd5;
    #1;
    vec++;
    if (b_ready !== 2'b01) begin
      miss++;
      $display("FAIL z_ready0: got %b want 01", b_ready);
    end
    tick();
    b_valid = 2'b00; b_commit = 2'b00;
    vec++;
    if (b_busy !== 1'b1 || b_err_pulse !== 1'b0) begin
      miss++;
      $display("FAIL z_commit_state: busy=%b err=%b want 1 0",
               b_busy, b_err_pulse);
    end
    tick();
    vec++;
    if (b_busy !== 1'b0 || b_B_out[5] !== B_W1 ||
        b_B_out[0] !== B_RST || b_commit_cnt !== 16'd1) begin
      miss++;
      $display("FAIL z_commit: busy=%b B5=%h B0=%h cnt=%0d want 0 %h %h 1",
               b_busy, b_B_out[5], b_B_out[0], b_commit_cnt, B_W1, B_RST);
    end
    b_valid = 2'b10; b_commit = 2'b10;
    b_sec[1] = 3'd0; b_A[1] = A_R1; b_B[1] = B_R1;
    #1;
    vec++;
    if (b_ready !== 2'b10) begin
      miss++;
      $display("FAIL z_regrant: got %b want 10", b_ready);
    end
    tick();
    b_valid = 2'b00; b_commit = 2'b00;
    tick();
    vec++;
    if (b_A_out[0] !== A_R1 || b_A_out[5] !== A_W1 ||
        b_commit_cnt !== 16'd2) begin
      miss++;
      $display("FAIL z_commit2: A0=%h A5=%h cnt=%0d want %h %h 2",
               b_A_out[0], b_A_out[5], b_commit_cnt, A_R1, A_W1);
    end
  endtask

  initial begin
    test_reset();
    test_staged_commit();
    test_round_robin();
    test_reject();
    test_reset_in_settle();
    test_zero_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
